// File: rtl/l2fp_arbiter.sv
// Round-robin arbiter sharing one long_to_fp converter among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining L2FP_ARB_WDOG_EN.
module l2fp_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int IDW         = 2,
   parameter int TIMEOUT_CYC = 128
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*64-1:0] req_data,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [NUM_REQ-1:0]    rsp_valid,
   input  logic [NUM_REQ-1:0]    rsp_ready,
   output logic [63:0]           rsp_data,
   output logic                  rsp_err,
   output logic                  cv_start,
   output logic [63:0]           cv_long_in,
   input  logic [63:0]           cv_fp_out,
   input  logic                  cv_done
);

   typedef enum logic [1:0] {
      ST_ARB   = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   rr_q, rr_d;
   logic [IDW-1:0]   gnt_q, gnt_d;
   logic [63:0]      long_q, long_d;
   logic [63:0]      data_q, data_d;
   logic             found_s;
   logic [IDW-1:0]   win_s;

`ifdef L2FP_ARB_WDOG_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;
`endif

   // Winner search from rr_q upward with wrap; descending loop leaves the nearest hit.
   always_comb begin
      int idx;
      found_s = 1'b0;
      win_s   = '0;
      idx     = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(rr_q) + k) % NUM_REQ;
         if (req_valid[idx]) begin
            found_s = 1'b1;
            win_s   = IDW'(idx);
         end
      end
   end

   // Next-state and combinational handshake outputs.
   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      gnt_d     = gnt_q;
      long_d    = long_q;
      data_d    = data_q;
      req_ready = '0;
`ifdef L2FP_ARB_WDOG_EN
      cnt_d     = cnt_q;
      err_d     = err_q;
`endif
      case (state_q)
         ST_ARB: begin
            if (found_s) begin
               req_ready[win_s] = 1'b1;
               long_d  = req_data[64*win_s +: 64];
               gnt_d   = win_s;
               rr_d    = (win_s == IDW'(NUM_REQ - 1)) ? '0 : win_s + IDW'(1);
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_ARB;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
`ifdef L2FP_ARB_WDOG_EN
            cnt_d   = '0;
`endif
         end
         ST_WAIT: begin
            if (cv_done) begin
               data_d  = cv_fp_out;
               state_d = ST_RESP;
`ifdef L2FP_ARB_WDOG_EN
            end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
               // Timed out: return quiet NaN flagged as an error.
               data_d  = 64'h7FF8_0000_0000_0000;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d   = cnt_q + CW'(1);
`else
            end else begin
               state_d = ST_WAIT;
`endif
            end
         end
         ST_RESP: begin
            if (rsp_ready[gnt_q]) begin
               state_d = ST_ARB;
`ifdef L2FP_ARB_WDOG_EN
               err_d   = 1'b0;
`endif
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_ARB;
         end
      endcase
   end

   // Result-valid is a decode of registered state and grant index.
   always_comb begin
      rsp_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_valid[i] = (state_q == ST_RESP) && (gnt_q == IDW'(i));
      end
   end

   assign cv_start   = (state_q == ST_ISSUE);
   assign cv_long_in = long_q;
   assign rsp_data   = data_q;
`ifdef L2FP_ARB_WDOG_EN
   assign rsp_err    = err_q;
`else
   assign rsp_err    = 1'b0;
`endif

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_ARB;
         rr_q    <= '0;
         gnt_q   <= '0;
         long_q  <= 64'd0;
         data_q  <= 64'd0;
`ifdef L2FP_ARB_WDOG_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         gnt_q   <= gnt_d;
         long_q  <= long_d;
         data_q  <= data_d;
`ifdef L2FP_ARB_WDOG_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_l2fp_arbiter.sv
// Directed self-checking bench for l2fp_arbiter with a fixed-latency converter stub.
module tb_l2fp_arbiter;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    req_valid = 4'd0;
   logic [255:0]  req_data = 256'd0;
   logic [3:0]    req_ready;
   logic [3:0]    rsp_valid;
   logic [3:0]    rsp_ready = 4'hF;
   logic [63:0]   rsp_data;
   logic          rsp_err;
   logic          cv_start;
   logic [63:0]   cv_long_in;
   logic [63:0]   cv_fp_out;
   logic          cv_done;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;

   // converter stub state
   logic          stub_busy;
   int            stub_cnt;
   logic [63:0]   stub_res;
   int            stub_lat = 5;
   bit            stub_never = 1'b0;

   l2fp_arbiter #(.NUM_REQ(4), .IDW(2), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .cv_start(cv_start), .cv_long_in(cv_long_in),
      .cv_fp_out(cv_fp_out), .cv_done(cv_done)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] conv(input logic [63:0] v);
      case (v)
         64'd0:                   conv = 64'h0000_0000_0000_0000;
         64'd1:                   conv = 64'h3FF0_0000_0000_0000;
         64'hFFFF_FFFF_FFFF_FFFE: conv = 64'hC000_0000_0000_0000;
         64'd5:                   conv = 64'h4014_0000_0000_0000;
         64'd10:                  conv = 64'h4024_0000_0000_0000;
         64'd20:                  conv = 64'h4034_0000_0000_0000;
         64'd30:                  conv = 64'h403E_0000_0000_0000;
         64'd40:                  conv = 64'h4044_0000_0000_0000;
         default:                 conv = 64'hDEAD_BEEF_DEAD_BEEF;
      endcase
   endfunction

   // Converter stub: done pulse stub_lat cycles after start is taken.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         stub_busy <= 1'b0;
         stub_cnt  <= 0;
         stub_res  <= 64'd0;
         cv_done   <= 1'b0;
         cv_fp_out <= 64'd0;
      end else begin
         cv_done <= 1'b0;
         if (stub_busy) begin
            if (stub_cnt == 1 && !stub_never) begin
               cv_done   <= 1'b1;
               cv_fp_out <= stub_res;
               stub_busy <= 1'b0;
            end else if (stub_cnt > 1) begin
               stub_cnt <= stub_cnt - 1;
            end
         end else if (cv_start) begin
            stub_busy <= 1'b1;
            stub_cnt  <= stub_lat;
            stub_res  <= conv(cv_long_in);
         end
      end
   end

   always @(posedge clk) begin
      if (cv_start) start_cnt <= start_cnt + 1;
   end

   task automatic send(input int idx, input logic [63:0] d, output bit ok);
      int n;
      @(negedge clk);
      req_valid[idx] = 1'b1;
      req_data[64*idx +: 64] = d;
      #1;
      n = 0;
      while (!req_ready[idx] && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      ok = req_ready[idx];
      @(negedge clk);
      req_valid[idx] = 1'b0;
   endtask

   task automatic wait_rsp(input int idx, output int n);
      n = 0;
      while (!rsp_valid[idx] && n < 300) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({req_ready, rsp_valid, rsp_data, rsp_err, cv_start, cv_long_in} !== 138'd0) begin
         errors++;
         $display("FAIL reset_outputs got rr=%b rv=%b rd=%h err=%b st=%b li=%h exp all zero",
                  req_ready, rsp_valid, rsp_data, rsp_err, cv_start, cv_long_in);
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      bit ok; int n;
      send(0, 64'd1, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL t1_grant got no req_ready exp grant"); end
      wait_rsp(0, n);
      checks++;
      if (n !== 7) begin errors++; $display("FAIL t1_latency got %0d exp 7", n); end
      checks++;
      if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL t1_valid got %b exp 0001", rsp_valid); end
      checks++;
      if (rsp_data !== 64'h3FF0_0000_0000_0000) begin
         errors++; $display("FAIL t1_data got %h exp 3ff0000000000000", rsp_data);
      end
      checks++;
      if (rsp_err !== 1'b0) begin errors++; $display("FAIL t1_err got %b exp 0", rsp_err); end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL t1_release got %b exp 0000", rsp_valid); end
   endtask

   task automatic test_sign_zero();
      bit ok; int n;
      stub_lat = 11;
      send(2, 64'hFFFF_FFFF_FFFF_FFFE, ok);
      wait_rsp(2, n);
      checks++;
      if (rsp_valid !== 4'b0100 || rsp_data !== 64'hC000_0000_0000_0000) begin
         errors++; $display("FAIL t2_neg got v=%b d=%h exp v=0100 d=c000000000000000", rsp_valid, rsp_data);
      end
      send(2, 64'd0, ok);
      wait_rsp(2, n);
      checks++;
      if (rsp_valid !== 4'b0100 || rsp_data !== 64'd0) begin
         errors++; $display("FAIL t2_zero got v=%b d=%h exp v=0100 d=0", rsp_valid, rsp_data);
      end
      stub_lat = 5;
   endtask

   task automatic test_round_robin();
      logic [63:0] exp_d [4];
      int n;
      exp_d[0] = 64'h4024_0000_0000_0000;
      exp_d[1] = 64'h4034_0000_0000_0000;
      exp_d[2] = 64'h403E_0000_0000_0000;
      exp_d[3] = 64'h4044_0000_0000_0000;
      @(negedge clk);
      rst = 1'b1;
      req_data = {64'd40, 64'd30, 64'd20, 64'd10};
      req_valid = 4'hF;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         #1;
         while (req_ready == 4'd0 && n < 200) begin @(negedge clk); #1; n++; end
         checks++;
         if (req_ready !== (4'b0001 << i)) begin
            errors++; $display("FAIL t3_grant%0d got %b exp %b", i, req_ready, 4'b0001 << i);
         end
         @(negedge clk);
         req_valid[i] = 1'b0;
         wait_rsp(i, n);
         checks++;
         if (rsp_valid !== (4'b0001 << i) || rsp_data !== exp_d[i]) begin
            errors++; $display("FAIL t3_rsp%0d got v=%b d=%h exp v=%b d=%h",
                               i, rsp_valid, rsp_data, 4'b0001 << i, exp_d[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      bit ok; int n; int s0;
      rsp_ready = 4'b0001;
      send(1, 64'd20, ok);
      req_data[63:0] = 64'd10;
      req_valid[0] = 1'b1;
      wait_rsp(1, n);
      s0 = start_cnt;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 4'b0010 || rsp_data !== 64'h4034_0000_0000_0000) begin
            errors++; $display("FAIL t4_hold%0d got v=%b d=%h exp v=0010 d=4034000000000000",
                               i, rsp_valid, rsp_data);
         end
      end
      checks++;
      if (start_cnt !== s0) begin errors++; $display("FAIL t4_nostart got %0d exp %0d", start_cnt, s0); end
      rsp_ready = 4'b0011;
      @(negedge clk); #1;
      checks++;
      if (req_ready !== 4'b0001) begin errors++; $display("FAIL t4_next_grant got %b exp 0001", req_ready); end
      @(negedge clk);
      req_valid[0] = 1'b0;
      wait_rsp(0, n);
      checks++;
      if (rsp_valid !== 4'b0001 || rsp_data !== 64'h4024_0000_0000_0000) begin
         errors++; $display("FAIL t4_rsp0 got v=%b d=%h exp v=0001 d=4024000000000000", rsp_valid, rsp_data);
      end
      rsp_ready = 4'hF;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit ok; bit stale; int n;
      send(2, 64'd30, ok);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({req_ready, rsp_valid, rsp_data, rsp_err, cv_start, cv_long_in} !== 138'd0) begin
         errors++;
         $display("FAIL t5_reset got rr=%b rv=%b rd=%h err=%b st=%b li=%h exp all zero",
                  req_ready, rsp_valid, rsp_data, rsp_err, cv_start, cv_long_in);
      end
      @(negedge clk);
      rst = 1'b0;
      stale = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (rsp_valid !== 4'b0000 || cv_start !== 1'b0) stale = 1'b1;
      end
      checks++;
      if (stale) begin errors++; $display("FAIL t5_stale got activity after reset exp none"); end
      send(3, 64'd5, ok);
      wait_rsp(3, n);
      checks++;
      if (rsp_valid !== 4'b1000 || rsp_data !== 64'h4014_0000_0000_0000) begin
         errors++; $display("FAIL t5_rsp3 got v=%b d=%h exp v=1000 d=4014000000000000", rsp_valid, rsp_data);
      end
      @(negedge clk);
   endtask

`ifdef L2FP_ARB_WDOG_EN
   task automatic test_watchdog();
      bit ok; int n;
      stub_never = 1'b1;
      send(0, 64'd1, ok);
      wait_rsp(0, n);
      checks++;
      if (n !== 17) begin errors++; $display("FAIL t6_latency got %0d exp 17", n); end
      checks++;
      if (rsp_err !== 1'b1 || rsp_data !== 64'h7FF8_0000_0000_0000) begin
         errors++; $display("FAIL t6_timeout got err=%b d=%h exp err=1 d=7ff8000000000000", rsp_err, rsp_data);
      end
      @(negedge clk);
      checks++;
      if (rsp_err !== 1'b0) begin errors++; $display("FAIL t6_err_clear got %b exp 0", rsp_err); end
      rst = 1'b1;
      stub_never = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_sign_zero();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
`ifdef L2FP_ARB_WDOG_EN
      test_watchdog();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
